// File: rtl/ooo_pkg.sv
// Shared OoO core definitions: physical tag space used by the free list and
// the tag reclaimer.
package ooo_pkg;
  localparam int NUM_PHYSICAL_REGS = 64;
  localparam int TAG_WIDTH         = 6;

  typedef logic [TAG_WIDTH-1:0] phys_tag_t;

  // x0 mapping; never enters the free list.
  localparam phys_tag_t ARCH_ZERO_TAG = '0;
endpackage

// File: rtl/phys_tag_reclaimer_if.sv
// Release/return bundle between ROB retire/squash, the tag reclaimer and the
// free list. slave = reclaimer side, master = environment side.
interface phys_tag_reclaimer_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int QUEUE_DEPTH  = 16
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [COMMIT_WIDTH-1:0]               commit_valid;
  ooo_pkg::phys_tag_t [COMMIT_WIDTH-1:0] commit_old_tag;
  logic                                  squash_valid;
  ooo_pkg::phys_tag_t                    squash_tag;
  logic                                  accept_ready;
  logic                                  free_list_full;
  ooo_pkg::phys_tag_t                    return_tag;
  logic                                  return_valid;
  logic [CNT_W-1:0]                      pending_count;
  logic                                  empty;
  logic                                  overflow_err;
  logic                                  double_free_err;

  modport master (
    output commit_valid, commit_old_tag, squash_valid, squash_tag, free_list_full,
    input  accept_ready, return_tag, return_valid, pending_count, empty,
           overflow_err, double_free_err
  );

  modport slave (
    input  commit_valid, commit_old_tag, squash_valid, squash_tag, free_list_full,
    output accept_ready, return_tag, return_valid, pending_count, empty,
           overflow_err, double_free_err
  );
endinterface

// File: rtl/multi_write_fifo.sv
// Circular buffer with NUM_WR write ports packed into consecutive tail slots
// and a single read port. Caller guarantees room for all asserted writes.
module multi_write_fifo #(
  parameter int WIDTH  = 6,
  parameter int DEPTH  = 16,
  parameter int NUM_WR = 3,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [CNT_W-1:0]             count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [PTR_W-1:0]             head, tail;
  logic [NUM_WR-1:0][PTR_W-1:0] slot;
  logic [CNT_W-1:0]             n_wr;

  // Each enabled port lands after the enabled ports below it.
  always_comb begin
    n_wr = '0;
    slot = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      slot[i] = tail + n_wr[PTR_W-1:0];
      n_wr    = n_wr + CNT_W'(wr_en[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WR; i++)
      if (wr_en[i]) mem[slot[i]] <= wr_data[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (rd_en) head <= head + 1'b1;
      tail  <= tail + n_wr[PTR_W-1:0];
      count <= count + n_wr - CNT_W'(rd_en);
    end
  end

  assign rd_data = mem[head];
endmodule

// File: rtl/phys_tag_reclaimer.sv
// Filters retire/squash tag releases (x0, double frees, overflow), buffers
// them and returns one tag per cycle to the free list through a flop stage.
module phys_tag_reclaimer
  import ooo_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int QUEUE_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  phys_tag_reclaimer_if.slave bus
);
  localparam int NUM_SRC = COMMIT_WIDTH + 1;
  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;

  logic [NUM_PHYSICAL_REGS-1:0] pending;
  logic [NUM_SRC-1:0]           src_vld, src_ok, src_dup;
  phys_tag_t [NUM_SRC-1:0]      src_tag;
  logic                         any_vld, ready, pop;
  phys_tag_t                    head_tag;
  logic [CNT_W-1:0]             count;
  logic                         ovf_q, dbl_q, ret_vld_q;
  phys_tag_t                    ret_tag_q;

  // Source order: commit lanes low, squash on top.
  assign src_vld = {bus.squash_valid, bus.commit_valid};
  assign src_tag = {bus.squash_tag, bus.commit_old_tag};
  assign any_vld = |src_vld;

  // Worst case one cycle adds NUM_SRC tags; judged on registered count only.
  assign ready = (count <= CNT_W'(QUEUE_DEPTH - NUM_SRC));
  assign pop   = (count != '0) && !bus.free_list_full;

  always_comb begin
    src_ok  = '0;
    src_dup = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_vld[i] && src_tag[i] != ARCH_ZERO_TAG) begin
        src_dup[i] = pending[src_tag[i]];
        for (int j = 0; j < i; j++)
          if (src_vld[j] && src_tag[j] == src_tag[i]) src_dup[i] = 1'b1;
        src_ok[i] = ready && !src_dup[i];
      end
    end
  end

  multi_write_fifo #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (QUEUE_DEPTH),
    .NUM_WR(NUM_SRC),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (src_ok),
    .wr_data(src_tag),
    .rd_en  (pop),
    .rd_data(head_tag),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      ovf_q     <= 1'b0;
      dbl_q     <= 1'b0;
      ret_vld_q <= 1'b0;
      ret_tag_q <= ARCH_ZERO_TAG;
    end else begin
      if (any_vld && !ready) ovf_q <= 1'b1;
      if (ready && |src_dup) dbl_q <= 1'b1;
      ret_vld_q <= pop;
      // A popped tag is pending, so it can never also be enqueued this cycle.
      if (pop) begin
        ret_tag_q         <= head_tag;
        pending[head_tag] <= 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++)
        if (src_ok[i]) pending[src_tag[i]] <= 1'b1;
    end
  end

  assign bus.accept_ready    = ready;
  assign bus.return_tag      = ret_tag_q;
  assign bus.return_valid    = ret_vld_q;
  assign bus.pending_count   = count;
  assign bus.empty           = (count == '0);
  assign bus.overflow_err    = ovf_q;
  assign bus.double_free_err = dbl_q;
endmodule

// File: tb/tb_phys_tag_reclaimer.sv
// Directed plus randomized check of phys_tag_reclaimer against a queue-based
// reference model of the release/return rules.
module tb_phys_tag_reclaimer;
  localparam int CW = 2;
  localparam int QD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phys_tag_reclaimer_if #(.COMMIT_WIDTH(CW), .QUEUE_DEPTH(QD)) bus ();

  phys_tag_reclaimer #(.COMMIT_WIDTH(CW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: the buffer as a queue of tags, plus registered outputs.
  int q[$];
  bit mpend[64];
  bit movf, mdbl, mrv;
  int mrt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rv"}, 32'(bus.return_valid), 32'(mrv));
    if (mrv) chk({tag, ".rt"}, 32'(bus.return_tag), mrt);
    chk({tag, ".cnt"}, 32'(bus.pending_count), q.size());
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".rdy"}, 32'(bus.accept_ready), 32'((QD - q.size()) >= CW + 1));
    chk({tag, ".ovf"}, 32'(bus.overflow_err), 32'(movf));
    chk({tag, ".dbl"}, 32'(bus.double_free_err), 32'(mdbl));
  endtask

  task automatic model_reset();
    q.delete();
    foreach (mpend[i]) mpend[i] = 1'b0;
    movf = 0; mdbl = 0; mrv = 0; mrt = 0;
  endtask

  task automatic drive_idle();
    bus.commit_valid      = '0;
    bus.commit_old_tag[0] = '0;
    bus.commit_old_tag[1] = '0;
    bus.squash_valid      = 1'b0;
    bus.squash_tag        = '0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_all(tag);
  endtask

  // One clock: present sources, advance the model, check after the edge.
  task automatic step(input string tag, input logic [1:0] cv, input int t0, input int t1,
                      input logic sv, input int st, input logic full);
    bit sv_a[3];
    int st_a[3];
    bit seen[64];
    int add[$];
    bit ready, pop;
    bus.commit_valid      = cv;
    bus.commit_old_tag[0] = 6'(t0);
    bus.commit_old_tag[1] = 6'(t1);
    bus.squash_valid      = sv;
    bus.squash_tag        = 6'(st);
    bus.free_list_full    = full;
    sv_a = '{cv[0], cv[1], sv};
    st_a = '{t0, t1, st};
    ready = (QD - q.size()) >= CW + 1;
    pop   = (q.size() > 0) && !full;
    if ((cv != 0 || sv) && !ready) movf = 1;
    else
      for (int i = 0; i < 3; i++)
        if (sv_a[i] && st_a[i] != 0) begin
          if (mpend[st_a[i]] || seen[st_a[i]]) mdbl = 1;
          else add.push_back(st_a[i]);
          seen[st_a[i]] = 1;
        end
    if (pop) begin
      mrt = q.pop_front();
      mpend[mrt] = 0;
      mrv = 1;
    end else mrv = 0;
    foreach (add[i]) begin
      q.push_back(add[i]);
      mpend[add[i]] = 1;
    end
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic idle(input string tag, input logic full);
    step(tag, 2'b00, 0, 0, 1'b0, 0, full);
  endtask

  initial begin
    int k;
    drive_idle();
    bus.free_list_full = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Two lanes in one cycle: 33 then 34, two edges after acceptance.
    step("pair", 2'b11, 33, 34, 1'b0, 0, 1'b0);
    chk("pair.cnt2", 32'(bus.pending_count), 2);
    chk("pair.norv", 32'(bus.return_valid), 0);
    idle("pair_d1", 1'b0);
    chk("pair.t33", 32'(bus.return_tag), 33);
    idle("pair_d2", 1'b0);
    chk("pair.t34", 32'(bus.return_tag), 34);
    chk("pair.cnt0", 32'(bus.pending_count), 0);
    idle("pair_d3", 1'b0);
    chk("pair.rv0", 32'(bus.return_valid), 0);

    // x0 release is dropped silently.
    step("x0", 2'b11, 0, 40, 1'b0, 0, 1'b0);
    chk("x0.cnt1", 32'(bus.pending_count), 1);
    repeat (3) idle("x0_d", 1'b0);
    chk("x0.dbl0", 32'(bus.double_free_err), 0);

    // Double free of 45 while still pending, then legal re-release.
    step("df1", 2'b01, 45, 0, 1'b0, 0, 1'b0);
    step("df2", 2'b01, 45, 0, 1'b0, 0, 1'b0);
    chk("df.dbl1", 32'(bus.double_free_err), 1);
    repeat (2) idle("df_d", 1'b0);
    step("df3", 2'b01, 45, 0, 1'b0, 0, 1'b0);
    chk("df3.cnt1", 32'(bus.pending_count), 1);
    repeat (3) idle("df_d2", 1'b0);

    // Fill with the free list stalled, then overflow.
    k = 0;
    while ((QD - q.size()) >= CW + 1) begin
      step("fill", 2'b11, 1 + 2 * k, 2 + 2 * k, 1'b0, 0, 1'b1);
      k++;
    end
    chk("fill.cnt14", 32'(bus.pending_count), 14);
    chk("fill.rdy0", 32'(bus.accept_ready), 0);
    step("ovf", 2'b11, 20, 21, 1'b0, 0, 1'b1);
    chk("ovf.err", 32'(bus.overflow_err), 1);
    chk("ovf.cnt14", 32'(bus.pending_count), 14);
    repeat (3) idle("drain", 1'b0);

    // Mixed commit + squash while draining keeps order 50, 51, 52.
    step("mix", 2'b11, 50, 51, 1'b1, 52, 1'b0);
    chk("mix.cnt13", 32'(bus.pending_count), 13);
    repeat (16) idle("mix_d", 1'b0);

    // Reset with five tags pending; they must be re-acceptable afterwards.
    step("pre1", 2'b11, 60, 61, 1'b0, 0, 1'b1);
    step("pre2", 2'b11, 62, 63, 1'b1, 59, 1'b1);
    chk("pre.cnt5", 32'(bus.pending_count), 5);
    do_reset("midrst");
    step("reacc", 2'b11, 60, 61, 1'b1, 62, 1'b0);
    chk("reacc.dbl0", 32'(bus.double_free_err), 0);
    repeat (4) idle("reacc_d", 1'b0);

    // Randomized traffic, with a reset between two rounds.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 500; c++)
        step("rnd", 2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
             1'($urandom_range(0, 2) == 0), $urandom_range(0, 15), 1'($urandom_range(0, 3) == 0));
      do_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
